// File: rtl/vid_timing_ctrl.sv
// Video timing controller for a DVI/HDMI style pixel pipeline.
//
// Generates the raster (hcnt/vcnt), decodes active video and sync windows, pulls
// pixels from a valid/ready source during the active region and presents them,
// registered one cycle later, to a DVI encoder. A run request is honoured only at
// frame boundaries, so a started frame always completes unless reset aborts it.
//
// Ports:
//   PixelClk      in   1   pixel clock, all state on its rising edge
//   aRst          in   1   asynchronous active-high reset
//   en            in   1   run request, sampled in IDLE and at the frame-end cycle
//   pix_valid     in   1   source has a pixel
//   pix_data      in  24   source pixel RGB
//   pix_ready     out  1   pixel consumed this cycle (combinational)
//   vid_pData     out 24   pixel to the encoder
//   vid_pVDE      out  1   active video
//   vid_pHSync    out  1   horizontal sync, active level HS_POL
//   vid_pVSync    out  1   vertical sync, active level VS_POL
//   frame_start   out  1   one-cycle pulse alongside the first pixel of a frame
//   underflow     out  1   sticky: a pixel was missing in the active region
//   underflow_clr in   1   clears underflow (a simultaneous new event wins)
module vid_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter logic [23:0] IDLE_RGB = 24'h000000
) (
  input  logic        PixelClk,
  input  logic        aRst,
  input  logic        en,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic [23:0] vid_pData,
  output logic        vid_pVDE,
  output logic        vid_pHSync,
  output logic        vid_pVSync,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam logic [11:0] HTotal     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] VTotal     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] HActive    = 12'(H_ACTIVE);
  localparam logic [11:0] VActive    = 12'(V_ACTIVE);
  localparam logic [11:0] HSyncStart = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HSyncEnd   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VSyncStart = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VSyncEnd   = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {StIdle, StRun} stateT;

  stateT       state;
  logic [11:0] hCnt;
  logic [11:0] vCnt;

  logic isRun;
  logic inActive;
  logic inHSync;
  logic inVSync;
  logic lineEnd;
  logic lastLine;
  logic missing;

  // Decode of the current counter state; registered into the outputs below.
  assign isRun    = (state == StRun);
  assign inActive = isRun && (hCnt < HActive) && (vCnt < VActive);
  assign inHSync  = isRun && (hCnt >= HSyncStart) && (hCnt < HSyncEnd);
  // VSync depends on vcnt only, so it changes together with the hcnt wrap.
  assign inVSync  = isRun && (vCnt >= VSyncStart) && (vCnt < VSyncEnd);
  assign lineEnd  = (hCnt == HTotal - 12'd1);
  assign lastLine = (vCnt == VTotal - 12'd1);
  assign missing  = inActive && !pix_valid;

  // Pixels offered outside the active region are never consumed.
  assign pix_ready = inActive && pix_valid;

  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      state       <= StIdle;
      hCnt        <= 12'd0;
      vCnt        <= 12'd0;
      vid_pData   <= 24'h0;
      vid_pVDE    <= 1'b0;
      vid_pHSync  <= ~HS_POL;
      vid_pVSync  <= ~VS_POL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          hCnt        <= 12'd0;
          vCnt        <= 12'd0;
          vid_pData   <= 24'h0;
          vid_pVDE    <= 1'b0;
          vid_pHSync  <= ~HS_POL;
          vid_pVSync  <= ~VS_POL;
          frame_start <= 1'b0;
          // Every output, the sticky flag included, rests at its reset value while idle.
          underflow   <= 1'b0;
          if (en) begin
            state <= StRun;
          end
        end

        StRun: begin
          if (lineEnd) begin
            hCnt <= 12'd0;
            vCnt <= lastLine ? 12'd0 : vCnt + 12'd1;
            // en is only looked at here, so a frame in flight always finishes.
            if (lastLine && !en) begin
              state <= StIdle;
            end
          end else begin
            hCnt <= hCnt + 12'd1;
          end

          vid_pVDE    <= inActive;
          vid_pHSync  <= inHSync ? HS_POL : ~HS_POL;
          vid_pVSync  <= inVSync ? VS_POL : ~VS_POL;
          frame_start <= (hCnt == 12'd0) && (vCnt == 12'd0);

          if (!inActive) begin
            vid_pData <= 24'h0;
          end else if (pix_valid) begin
            vid_pData <= pix_data;
          end else begin
            vid_pData <= IDLE_RGB;
          end

          // A new miss overrides a clear issued in the same cycle.
          underflow <= missing || (underflow && !underflow_clr);
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vid_timing_ctrl.sv
// Self-checking bench for vid_timing_ctrl with a reduced raster so whole frames
// fit in a short run: 144 clocks per line, 18 lines, 2592 clocks per frame.
module tb_vid_timing_ctrl;

  localparam int HA = 128, HF = 4, HSW = 8, HB = 4;
  localparam int VA = 12, VF = 2, VSW = 2, VB = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] IDLE_RGB = 24'hA5A5A5;
  // {data, vde, hsync, vsync, frame_start, underflow} at reset, both polarities 0.
  localparam logic [28:0] RST_O = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  typedef struct packed {
    logic [23:0] d;
    logic        vde;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        uf;
  } outsT;

  logic        PixelClk;
  logic        aRst;
  logic        en;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic [23:0] vid_pData;
  logic        vid_pVDE;
  logic        vid_pHSync;
  logic        vid_pVSync;
  logic        frame_start;
  logic        underflow;
  logic        underflow_clr;

  vid_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .IDLE_RGB(IDLE_RGB)
  ) dut (
    .PixelClk(PixelClk), .aRst(aRst), .en(en), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .vid_pData(vid_pData),
    .vid_pVDE(vid_pVDE), .vid_pHSync(vid_pHSync), .vid_pVSync(vid_pVSync),
    .frame_start(frame_start), .underflow(underflow), .underflow_clr(underflow_clr)
  );

  initial PixelClk = 1'b0;
  always #5 PixelClk = ~PixelClk;

  outsT        actO;
  assign actO = {vid_pData, vid_pVDE, vid_pHSync, vid_pVSync, frame_start, underflow};

  int          nChecks = 0;
  int          nPass = 0;
  outsT        q[$];
  outsT        expO;
  logic        expReady;
  logic        obsReady;
  logic [23:0] pdc = 24'd0;
  // Reference raster model, advanced once per driven cycle.
  bit          mRun = 1'b0;
  int          mH = 0;
  int          mV = 0;
  logic        mUf = 1'b0;

  // Drive one cycle of inputs, predict the registered outputs they produce and queue them.
  task automatic step(input logic e, input logic pv, input logic [23:0] pd, input logic c);
    outsT o;
    logic act;
    en = e; pix_valid = pv; pix_data = pd; underflow_clr = c;
    act   = mRun && (mH < HA) && (mV < VA);
    o.d   = !act ? 24'h0 : (pv ? pd : IDLE_RGB);
    o.vde = act;
    o.hs  = (mRun && mH >= HA + HF && mH < HA + HF + HSW) ? 1'b0 : 1'b1;
    o.vs  = (mRun && mV >= VA + VF && mV < VA + VF + VSW) ? 1'b0 : 1'b1;
    o.fs  = mRun && (mH == 0) && (mV == 0);
    o.uf  = mRun && ((act && !pv) || (mUf && !c));
    mUf = o.uf;
    q.push_back(o);
    expReady = act && pv;
    if (!mRun) begin
      if (e) begin mRun = 1'b1; mH = 0; mV = 0; end
    end else if (mH == HT - 1) begin
      mH = 0;
      if (mV == VT - 1) begin
        mV = 0;
        if (!e) mRun = 1'b0;
      end else begin
        mV++;
      end
    end else begin
      mH++;
    end
  endtask

  // One clock: drive, sample the combinational ready, then pop the prediction for the output.
  task automatic cycle(input logic e, input logic pv, input logic [23:0] pd, input logic c);
    step(e, pv, pd, c);
    #1 obsReady = pix_ready;
    @(negedge PixelClk);
    expO = q.pop_front();
  endtask

  // Run with en=1 and valid pixels until the model sits at (h, v); ok=0 if never reached.
  task automatic seek(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (mRun && mH == h && mV == v) begin ok = 1'b1; break; end
      cycle(1'b1, 1'b1, pdc, 1'b0); pdc++;
    end
  endtask

  task automatic test_reset();
    aRst = 1'b1; en = 1'b0; pix_valid = 1'b1; pix_data = 24'h123456; underflow_clr = 1'b0;
    repeat (3) @(negedge PixelClk);
    nChecks++; if (actO !== RST_O) $display("FAIL reset_outs: got %h want %h", actO, RST_O); else nPass++;
    nChecks++; if (pix_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", pix_ready); else nPass++;
    aRst = 1'b0;
    // Not yet enabled: must stay idle across a few edges.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, pdc, 1'b0);
      nChecks++; if (actO !== expO) $display("FAIL idle_outs: got %h want %h", actO, expO); else nPass++;
    end
  endtask

  task automatic test_frame();
    int fs1 = -1, fs2 = -1, rise1 = -1, rise2 = -1, hsFall = -1, vsFall = -1;
    int readyCnt = 0, vdeCnt = 0, hsLow = 0, vsLow = 0, run1 = 0;
    logic pV = 1'b0, pH = 1'b1, pS = 1'b1;
    for (int k = 0; k < FRAME + 10; k++) begin
      cycle(1'b1, 1'b1, pdc, 1'b0); pdc++;
      nChecks++; if (obsReady !== expReady) $display("FAIL frame_ready: got %b want %b", obsReady, expReady); else nPass++;
      nChecks++; if (actO !== expO) $display("FAIL frame_outs: got %h want %h", actO, expO); else nPass++;
      if (frame_start) begin
        if (fs1 < 0) begin
          fs1 = k;
          nChecks++; if (vid_pVDE !== 1'b1) $display("FAIL fs_vde: got %b want 1", vid_pVDE); else nPass++;
        end else if (fs2 < 0) begin
          fs2 = k;
        end
      end
      if (fs1 >= 0 && fs2 < 0) begin
        if (obsReady) readyCnt++;
        if (vid_pVDE) vdeCnt++;
        if (!vid_pHSync) hsLow++;
        if (!vid_pVSync) vsLow++;
        if (vid_pVDE && !pV) begin
          if (rise1 < 0) rise1 = k; else if (rise2 < 0) rise2 = k;
        end
        if (vid_pVDE && rise2 < 0) run1++;
        if (!vid_pHSync && pH && hsFall < 0) hsFall = k;
        if (!vid_pVSync && pS && vsFall < 0) vsFall = k;
      end
      pV = vid_pVDE; pH = vid_pHSync; pS = vid_pVSync;
    end
    nChecks++; if (fs2 - fs1 !== FRAME) $display("FAIL frame_period: got %0d want %0d", fs2 - fs1, FRAME); else nPass++;
    nChecks++; if (readyCnt !== HA * VA) $display("FAIL ready_count: got %0d want %0d", readyCnt, HA * VA); else nPass++;
    nChecks++; if (vdeCnt !== HA * VA) $display("FAIL vde_count: got %0d want %0d", vdeCnt, HA * VA); else nPass++;
    nChecks++; if (rise2 - rise1 !== HT) $display("FAIL line_period: got %0d want %0d", rise2 - rise1, HT); else nPass++;
    nChecks++; if (run1 !== HA) $display("FAIL vde_per_line: got %0d want %0d", run1, HA); else nPass++;
    nChecks++; if (hsFall - rise1 !== HA + HF) $display("FAIL hsync_offset: got %0d want %0d", hsFall - rise1, HA + HF); else nPass++;
    nChecks++; if (hsLow !== HSW * VT) $display("FAIL hsync_width: got %0d want %0d", hsLow, HSW * VT); else nPass++;
    nChecks++; if (vsFall - fs1 !== (VA + VF) * HT) $display("FAIL vsync_start: got %0d want %0d", vsFall - fs1, (VA + VF) * HT); else nPass++;
    nChecks++; if (vsLow !== VSW * HT) $display("FAIL vsync_width: got %0d want %0d", vsLow, VSW * HT); else nPass++;
  endtask

  task automatic test_underflow();
    bit ok;
    seek(100, 5, ok);
    nChecks++; if (!ok) $display("FAIL seek_uf: got 0 want 1"); else nPass++;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, pdc, 1'b0); pdc++;
      nChecks++; if (obsReady !== 1'b0) $display("FAIL gap_ready: got %b want 0", obsReady); else nPass++;
      nChecks++; if (vid_pData !== IDLE_RGB) $display("FAIL gap_data: got %h want %h", vid_pData, IDLE_RGB); else nPass++;
      nChecks++; if (underflow !== 1'b1) $display("FAIL uf_set: got %b want 1", underflow); else nPass++;
      nChecks++; if (actO !== expO) $display("FAIL gap_outs: got %h want %h", actO, expO); else nPass++;
    end
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b1, pdc, 1'b0); pdc++;
      nChecks++; if (actO !== expO) $display("FAIL post_gap_outs: got %h want %h", actO, expO); else nPass++;
    end
    nChecks++; if (underflow !== 1'b1) $display("FAIL uf_sticky: got %b want 1", underflow); else nPass++;
  endtask

  task automatic test_clr_collision();
    bit ok;
    seek(20, 6, ok);
    nChecks++; if (!ok) $display("FAIL seek_clr: got 0 want 1"); else nPass++;
    cycle(1'b1, 1'b0, pdc, 1'b1); pdc++;
    nChecks++; if (underflow !== 1'b1) $display("FAIL clr_collision: got %b want 1", underflow); else nPass++;
    nChecks++; if (actO !== expO) $display("FAIL collision_outs: got %h want %h", actO, expO); else nPass++;
    cycle(1'b1, 1'b1, pdc, 1'b1); pdc++;
    nChecks++; if (underflow !== 1'b0) $display("FAIL clr: got %b want 0", underflow); else nPass++;
    seek(HA, 6, ok);
    nChecks++; if (!ok) $display("FAIL seek_blank: got 0 want 1"); else nPass++;
    // No valid data at all across horizontal blanking: must not count as underflow.
    for (int k = 0; k < HT - HA; k++) begin
      cycle(1'b1, 1'b0, pdc, 1'b0); pdc++;
      nChecks++; if (obsReady !== expReady) $display("FAIL blank_ready: got %b want %b", obsReady, expReady); else nPass++;
      nChecks++; if (actO !== expO) $display("FAIL blank_outs: got %h want %h", actO, expO); else nPass++;
    end
    nChecks++; if (underflow !== 1'b0) $display("FAIL blank_uf: got %b want 0", underflow); else nPass++;
  endtask

  task automatic test_en_drop();
    bit ok;
    int vsLow = 0;
    logic e;
    seek(0, 8, ok);
    nChecks++; if (!ok) $display("FAIL seek_en: got 0 want 1"); else nPass++;
    for (int k = 0; k < FRAME && mRun; k++) begin
      e = (mV == 10 && mH < 5);  // brief mid-frame glitch on en must be ignored
      cycle(e, 1'b1, pdc, 1'b0); pdc++;
      nChecks++; if (actO !== expO) $display("FAIL drain_outs: got %h want %h", actO, expO); else nPass++;
      if (!vid_pVSync) vsLow++;
    end
    nChecks++; if (vsLow !== VSW * HT) $display("FAIL drain_vsync: got %0d want %0d", vsLow, VSW * HT); else nPass++;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b1, pdc, 1'b0); pdc++;
      nChecks++; if (actO !== RST_O) $display("FAIL idle_after_drop: got %h want %h", actO, RST_O); else nPass++;
      nChecks++; if (obsReady !== 1'b0) $display("FAIL idle_ready: got %b want 0", obsReady); else nPass++;
    end
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b1, pdc, 1'b0); pdc++;
      nChecks++; if (actO !== expO) $display("FAIL restart_outs: got %h want %h", actO, expO); else nPass++;
      if (k == 1) begin
        nChecks++; if (frame_start !== 1'b1) $display("FAIL restart_fs: got %b want 1", frame_start); else nPass++;
      end
    end
  endtask

  task automatic test_arst();
    bit ok;
    seek(100, 10, ok);
    nChecks++; if (!ok) $display("FAIL seek_rst: got 0 want 1"); else nPass++;
    step(1'b1, 1'b1, pdc, 1'b0);
    #2 aRst = 1'b1;
    #1;  // still before the next rising edge
    nChecks++; if (actO !== RST_O) $display("FAIL async_rst_outs: got %h want %h", actO, RST_O); else nPass++;
    nChecks++; if (pix_ready !== 1'b0) $display("FAIL async_rst_ready: got %b want 0", pix_ready); else nPass++;
    q.delete();
    mRun = 1'b0; mH = 0; mV = 0; mUf = 1'b0;
    @(negedge PixelClk);
    nChecks++; if (actO !== RST_O) $display("FAIL rst_held: got %h want %h", actO, RST_O); else nPass++;
    aRst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, 1'b1, pdc, 1'b0); pdc++;
      nChecks++; if (actO !== expO) $display("FAIL post_rst_outs: got %h want %h", actO, expO); else nPass++;
      if (k == 1) begin
        nChecks++; if (frame_start !== 1'b1) $display("FAIL post_rst_fs: got %b want 1", frame_start); else nPass++;
      end
    end
  endtask

  initial begin
    @(negedge PixelClk);
    test_reset();
    test_frame();
    test_underflow();
    test_clr_collision();
    test_en_drop();
    test_arst();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
